// File: rtl/divider_array_issue_ctrl.sv
// divider_array_issue_ctrl
//
// Issue/collect controller for an external combinational divider array.
// A request (in_n / in_d) is latched onto the array inputs, held for
// SETTLE_CYCLES cycles, then the array outputs are captured and offered to
// the consumer until it accepts them.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer side (in_valid/in_ready) transfers only in IDLE; the
// consumer side (out_valid/out_ready) only in DONE. in_ready and out_valid do
// not depend combinationally on in_valid or out_ready.
//
// Optional feature (macro DIV_OVF_CHECK_EN): divide-by-zero and quotient
// overflow detection on the latched operands. When it is not defined, the
// flags are tied 0 and the array result is passed through untouched.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_n[15:0], in_d[7:0] dividend, divisor
//   div_n, div_d          registered operands driven to the divider array
//   div_q, div_r          quotient / remainder from the divider array
//   out_valid/out_ready   result handshake
//   out_q, out_r          registered quotient / remainder
//   out_dbz, out_ovf      divide-by-zero / quotient-overflow flags
//   busy                  high whenever the FSM is not IDLE
//   dbg_state[1:0]        current FSM state (0 IDLE, 1 SETTLE, 2 DONE)
module divider_array_issue_ctrl #(
    parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_n,
    input  logic [7:0]  in_d,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_q,
    output logic [7:0]  out_r,
    output logic        out_dbz,
    output logic        out_ovf,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;

    // Result as it will be captured at the end of SETTLE.
    logic       res_dbz;
    logic       res_ovf;
    logic [7:0] res_q;
    logic [7:0] res_r;

`ifdef DIV_OVF_CHECK_EN
    // The quotient fits in 8 bits only when the upper dividend byte is
    // strictly below the divisor; otherwise the array output is meaningless.
    always_comb begin
        res_dbz = (div_d == 8'd0);
        res_ovf = !res_dbz && (div_n[15:8] >= div_d);
        res_q   = (res_dbz || res_ovf) ? 8'hFF : div_q;
        res_r   = res_dbz ? div_n[7:0] : div_r;
    end
`else
    always_comb begin
        res_dbz = 1'b0;
        res_ovf = 1'b0;
        res_q   = div_q;
        res_r   = div_r;
    end
`endif

    // rst_n gating keeps in_ready low while reset is held, so no accept can
    // appear to happen during reset.
    assign in_ready  = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            div_n     <= 16'd0;
            div_d     <= 8'd0;
            out_q     <= 8'd0;
            out_r     <= 8'd0;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_n <= in_n;
                        div_d <= in_d;
                        cnt   <= 4'(SETTLE_CYCLES - 1);
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        out_q     <= res_q;
                        out_r     <= res_r;
                        out_dbz   <= res_dbz;
                        out_ovf   <= res_ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the earliest next accept
                    // is one edge after the result handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_array_issue_ctrl.sv
module tb_divider_array_issue_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_n = 16'd0;
  logic [7:0]  in_d = 8'd0;
  logic [15:0] div_n;
  logic [7:0]  div_d;
  logic [7:0]  div_q;
  logic [7:0]  div_r;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_q;
  logic [7:0]  out_r;
  logic        out_dbz;
  logic        out_ovf;
  logic        busy;
  logic [1:0]  dbg_state;

  // Free-running throughput instances: [0] SETTLE_CYCLES=1, [1] =15.
  logic [15:0] tp_n = 16'd0;
  logic [7:0]  tp_d = 8'd1;
  logic        tp_in_ready[2];
  logic [15:0] tp_div_n[2];
  logic [7:0]  tp_div_d[2];
  logic [7:0]  tp_div_q[2];
  logic [7:0]  tp_div_r[2];
  logic        tp_out_valid[2];
  logic [7:0]  tp_out_q[2];
  logic [7:0]  tp_out_r[2];
  logic        tp_out_dbz[2];
  logic        tp_out_ovf[2];
  logic        tp_busy[2];
  logic [1:0]  tp_dbg[2];

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- divider array stand-in ----------------
  // Exact division for d != 0; an arbitrary recognisable pattern for d == 0.
  function automatic logic [15:0] arr(input logic [15:0] n, input logic [7:0] d);
    int q;
    int r;
    if (d == 8'd0) return {n[15:8] ^ 8'h5A, n[7:0] ^ 8'hC3};
    q = int'(n) / int'(d);
    r = int'(n) % int'(d);
    return {q[7:0], r[7:0]};
  endfunction

  assign {div_q, div_r} = arr(div_n, div_d);

  // ---------------- reference model: {dbz, ovf, q, r} ----------------
  function automatic logic [17:0] ref_res(input logic [15:0] n, input logic [7:0] d);
`ifdef DIV_OVF_CHECK_EN
    int q;
    int r;
    if (d == 8'd0) return {2'b10, 8'hFF, n[7:0]};
    q = int'(n) / int'(d);
    r = int'(n) % int'(d);
    if (q > 255) return {2'b01, 8'hFF, r[7:0]};
    return {2'b00, q[7:0], r[7:0]};
`else
    return {2'b00, arr(n, d)};
`endif
  endfunction

  divider_array_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_d(in_d), .div_n(div_n), .div_d(div_d),
    .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_ovf(out_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  for (genvar g = 0; g < 2; g++) begin : g_tp
    divider_array_issue_ctrl #(.SETTLE_CYCLES(g == 0 ? 1 : 15)) u_tp (
      .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .in_ready(tp_in_ready[g]),
      .in_n(tp_n), .in_d(tp_d), .div_n(tp_div_n[g]), .div_d(tp_div_d[g]),
      .div_q(tp_div_q[g]), .div_r(tp_div_r[g]), .out_valid(tp_out_valid[g]),
      .out_ready(1'b1), .out_q(tp_out_q[g]), .out_r(tp_out_r[g]),
      .out_dbz(tp_out_dbz[g]), .out_ovf(tp_out_ovf[g]), .busy(tp_busy[g]),
      .dbg_state(tp_dbg[g])
    );
    assign {tp_div_q[g], tp_div_r[g]} = arr(tp_div_n[g], tp_div_d[g]);
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, settle (with junk on the inputs), optional
  // backpressure, then result handshake with a junk request present.
  task automatic do_op(input logic [15:0] n, input logic [7:0] d, input int stall);
    logic [17:0] e;
    int lat;
    bit seen;
    exp_q.push_back(ref_res(n, d));
    check("in_ready_idle", in_ready, 1);
    in_n = n;
    in_d = d;
    in_valid = 1'b1;
    tick();
    check("busy_after_accept", busy, 1);
    check("div_n_latched", div_n, n);
    check("div_d_latched", div_d, d);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      in_n = 16'($urandom);
      in_d = 8'($urandom);
      out_ready = 1'($urandom);
      tick();
      lat++;
      if (out_valid) seen = 1;
    end
    out_ready = 1'b0;
    check("out_valid_seen", seen, 1);
    check("latency", lat, S);
    check("div_n_held_settle", {div_n, div_d}, {n, d});
    e = exp_q.pop_front();
    check("result", {out_dbz, out_ovf, out_q, out_r}, e);
    for (int i = 0; i < stall; i++) begin
      in_n = 16'($urandom);
      in_d = 8'($urandom);
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", {out_dbz, out_ovf, out_q, out_r}, e);
      check("stall_div_held", {div_n, div_d}, {n, d});
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_idle_no_accept", busy, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_div_held", {div_n, div_d}, {n, d});
  endtask

  // ---------------- throughput bookkeeping ----------------
  int  cyc = 0;
  logic rp[2];
  logic op[2];
  int  acc[2];
  bit  have[2];

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    tick();
    tick();
    check("rst_div_n", div_n, 0);
    check("rst_div_d", div_d, 0);
    check("rst_out", {out_dbz, out_ovf, out_q, out_r}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("rst_release_in_ready", in_ready, 1);

    // directed operations
    do_op(16'd1000, 8'd7, 0);
    check("q_1000_7", out_q, 8'd142);
    check("r_1000_7", out_r, 8'd6);
    do_op(16'h1234, 8'h00, 1);
    do_op(16'h0A00, 8'h0A, 0);
    do_op(16'h00FF, 8'h01, 0);
    do_op(16'hFFFF, 8'hFF, 0);
    do_op(16'h0123, 8'h45, 5);

    // randomized operations
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic [15:0] n;
      case ($urandom_range(0, 3))
        0: begin d = 8'd0; n = 16'($urandom); end
        1: begin d = 8'($urandom_range(1, 8)); n = 16'($urandom); end
        default: begin
          d = 8'($urandom_range(1, 255));
          n = 16'($urandom_range(0, int'(d) * 256 - 1));
        end
      endcase
      do_op(n, d, $urandom_range(0, 3));
    end

    // reset during SETTLE
    in_n = 16'h4321;
    in_d = 8'h21;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_div", {div_n, div_d}, 0);
    check("arst_out", {out_dbz, out_ovf, out_q, out_r}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
    end
    do_op(16'd1000, 8'd7, 0);

    // throughput of the SETTLE_CYCLES=1 and =15 instances
    rp[0] = tp_in_ready[0];
    rp[1] = tp_in_ready[1];
    op[0] = tp_out_valid[0];
    op[1] = tp_out_valid[1];
    have[0] = 0;
    have[1] = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
        if (rp[g]) begin
          if (have[g]) check($sformatf("tp_spacing_%0d", g), cyc - acc[g], (g == 0 ? 1 : 15) + 2);
          acc[g] = cyc;
          have[g] = 1;
        end
      end
      #1;
      for (int g = 0; g < 2; g++) begin
        if (tp_out_valid[g] && !op[g] && have[g])
          check($sformatf("tp_latency_%0d", g), cyc - acc[g], g == 0 ? 1 : 15);
        rp[g] = tp_in_ready[g];
        op[g] = tp_out_valid[g];
      end
      tp_n = 16'($urandom);
      tp_d = 8'($urandom);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
